// File: rtl/enc_pkg.sv
// Shared definitions for the sequential request encoder: FSM states, default
// code width and a one-hot helper used to build the acknowledge mask.
package enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 3;

  // The helper is sized for the widest supported code; callers truncate.
  localparam int MAX_WIDTH = 8;
  localparam int MAX_N     = 2 ** MAX_WIDTH;

  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_WIDTH-1:0] code);
    logic [MAX_N-1:0] mask;
    mask       = '0;
    mask[code] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/req_encoder_prio_pick.sv
// Combinational fixed-priority picker: returns the index of the winning set bit
// (highest or lowest index first) plus a flag telling whether any bit is set.
module prio_pick #(
  parameter int WIDTH     = 3,
  parameter bit LOW_FIRST = 1'b0,
  localparam int N        = 2 ** WIDTH
) (
  input  logic [N-1:0]     vec,
  output logic [WIDTH-1:0] idx,
  output logic             any
);

  // NOTE: every output gets a default before the loops so no latch is inferred.
  always_comb begin
    idx = '0;
    any = |vec;
    // The last match in scan order wins, so scan towards the preferred end.
    if (LOW_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/req_encoder.sv
// Sequential N-to-WIDTH request encoder: latches request strobes into a pending
// register and hands out their indices one per valid/ready handshake.
module req_encoder
  import enc_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LOW_FIRST = 1'b0,
  localparam int N        = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             clr,
  input  logic             ready,
  output logic [WIDTH-1:0] code,
  output logic             valid,
  output logic [N-1:0]     pending,
  output logic             ovf
);

  state_t           state, state_next;
  logic [WIDTH-1:0] code_next;
  logic             valid_next;
  logic             xfer;
  logic [N-1:0]     ack_mask;
  logic [N-1:0]     pending_next;
  logic             ovf_set;
  logic [WIDTH-1:0] pick_cur, pick_nxt;
  logic             any_cur, any_nxt;

  assign xfer         = valid && ready;
  assign ack_mask     = xfer ? N'(onehot(MAX_WIDTH'(code))) : '0;
  // OR-ing req last lets a new event survive an ack of the same bit.
  assign pending_next = (pending & ~ack_mask) | req;
  assign ovf_set      = |(req & pending & ~ack_mask);

  prio_pick #(.WIDTH(WIDTH), .LOW_FIRST(LOW_FIRST)) u_pick_cur (
    .vec (pending),
    .idx (pick_cur),
    .any (any_cur)
  );

  prio_pick #(.WIDTH(WIDTH), .LOW_FIRST(LOW_FIRST)) u_pick_nxt (
    .vec (pending_next),
    .idx (pick_nxt),
    .any (any_nxt)
  );

  always_comb begin
    state_next = state;
    code_next  = code;
    valid_next = valid;
    case (state)
      IDLE: begin
        valid_next = 1'b0;
        if (any_cur) begin
          code_next  = pick_cur;
          valid_next = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        // The held code only moves on a transfer; later arrivals never preempt it.
        if (xfer) begin
          if (any_nxt) begin
            code_next = pick_nxt;
          end else begin
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      code    <= '0;
      valid   <= 1'b0;
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_next;
      code    <= code_next;
      valid   <= valid_next;
      pending <= pending_next;
      if (ovf_set)  ovf <= 1'b1;
      else if (clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_req_encoder.sv
// Self-checking bench for req_encoder: directed scenarios for both priority
// orders, then randomized traffic compared against a behavioural model.
module tb_req_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       clr;
  logic       ready;
  logic [2:0] code0, code1;
  logic       valid0, valid1;
  logic [7:0] pending0, pending1;
  logic       ovf0, ovf1;

  int errors = 0;
  int checks = 0;

  // Behavioural model state: index 0 = highest-first, index 1 = lowest-first.
  logic [7:0] m_pend [2];
  int         m_code [2];
  bit         m_valid[2];
  bit         m_ovf  [2];

  always #5 clk = ~clk;

  req_encoder #(.WIDTH(3), .LOW_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .clr(clr), .code(code0),
    .valid(valid0), .ready(ready), .pending(pending0), .ovf(ovf0)
  );

  req_encoder #(.WIDTH(3), .LOW_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .clr(clr), .code(code1),
    .valid(valid1), .ready(ready), .pending(pending1), .ovf(ovf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int best(input logic [7:0] v, input bit low_first);
    if (low_first) begin
      for (int i = 0; i < 8; i++) if (v[i]) return i;
    end else begin
      for (int i = 7; i >= 0; i--) if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = '0; m_code[k] = 0; m_valid[k] = 0; m_ovf[k] = 0;
    end
  endtask

  // One rising edge: advance the model with the inputs seen at that edge,
  // then move 1 time unit past the edge so outputs are settled.
  task automatic step();
    logic [7:0] ack, nxt;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      ack = (m_valid[k] && ready) ? 8'(1 << m_code[k]) : 8'h00;
      nxt = (m_pend[k] & ~ack) | req;
      if ((req & m_pend[k] & ~ack) != 0) m_ovf[k] = 1;
      else if (clr)                      m_ovf[k] = 0;
      if (!m_valid[k]) begin
        if (m_pend[k] != 0) begin
          m_code[k]  = best(m_pend[k], k == 1);
          m_valid[k] = 1;
        end
      end else if (ready) begin
        if (nxt != 0) m_code[k] = best(nxt, k == 1);
        else          m_valid[k] = 0;
      end
      m_pend[k] = nxt;
    end
    #1;
  endtask

  task automatic compare_model();
    check("rnd_valid0", 32'(valid0), 32'(m_valid[0]));
    check("rnd_pend0", 32'(pending0), 32'(m_pend[0]));
    check("rnd_ovf0", 32'(ovf0), 32'(m_ovf[0]));
    if (m_valid[0]) check("rnd_code0", 32'(code0), 32'(m_code[0]));
    check("rnd_valid1", 32'(valid1), 32'(m_valid[1]));
    check("rnd_pend1", 32'(pending1), 32'(m_pend[1]));
    check("rnd_ovf1", 32'(ovf1), 32'(m_ovf[1]));
    if (m_valid[1]) check("rnd_code1", 32'(code1), 32'(m_code[1]));
  endtask

  initial begin
    rst_n = 1'b0; req = '0; clr = 1'b0; ready = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;
    check("rst_pending", 32'(pending0), 32'h00);
    check("rst_code", 32'(code0), 32'h0);
    check("rst_valid", 32'(valid0), 32'h0);
    check("rst_ovf", 32'(ovf0), 32'h0);

    // Single request
    ready = 1'b1; req = 8'b0000_0100;
    step();
    req = '0;
    check("single_pend_t1", 32'(pending0), 32'h04);
    check("single_valid_t1", 32'(valid0), 32'h0);
    step();
    check("single_valid_t2", 32'(valid0), 32'h1);
    check("single_code_t2", 32'(code0), 32'h2);
    step();
    check("single_valid_t3", 32'(valid0), 32'h0);
    check("single_pend_t3", 32'(pending0), 32'h00);
    check("single_ovf", 32'(ovf0), 32'h0);

    // Multi-hot burst, highest first
    req = 8'b1010_0011;
    step();
    req = '0;
    step(); check("burst_c7", 32'(code0), 32'h7); check("burst_v7", 32'(valid0), 32'h1);
    step(); check("burst_c5", 32'(code0), 32'h5); check("burst_v5", 32'(valid0), 32'h1);
    step(); check("burst_c1", 32'(code0), 32'h1); check("burst_v1", 32'(valid0), 32'h1);
    step(); check("burst_c0", 32'(code0), 32'h0); check("burst_v0", 32'(valid0), 32'h1);
    step(); check("burst_end", 32'(valid0), 32'h0);

    // Backpressure: code 6 held while 7 arrives
    ready = 1'b0; req = 8'b0100_1000;
    step();
    req = '0;
    step();
    for (int i = 0; i < 10; i++) begin
      req = (i == 3) ? 8'h80 : 8'h00;
      check("bp_hold_code", 32'(code0), 32'h6);
      check("bp_hold_valid", 32'(valid0), 32'h1);
      step();
    end
    req = '0; ready = 1'b1;
    step(); check("bp_seq_7", 32'(code0), 32'h7);
    step(); check("bp_seq_3", 32'(code0), 32'h3);
    step(); check("bp_seq_end", 32'(valid0), 32'h0);

    // Overflow from a request held three cycles
    ready = 1'b0; req = 8'h10;
    step(); check("ovf_first", 32'(ovf0), 32'h0);
    step(); step();
    req = '0;
    check("ovf_pend", 32'(pending0), 32'h10);
    check("ovf_set", 32'(ovf0), 32'h1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("ovf_clr", 32'(ovf0), 32'h0);
    clr = 1'b1; req = 8'h10;
    step();
    clr = 1'b0; req = '0;
    check("ovf_clr_vs_set", 32'(ovf0), 32'h1);
    ready = 1'b1;
    step(); check("ovf_drain", 32'(valid0), 32'h0);
    clr = 1'b1;
    step();
    clr = 1'b0;

    // Set and ack of the same bit in one cycle
    req = 8'h20;
    step();
    req = '0;
    step();
    check("coll_code", 32'(code0), 32'h5);
    req = 8'h20;
    step();
    req = '0;
    check("coll_pend", 32'(pending0), 32'h20);
    check("coll_valid", 32'(valid0), 32'h1);
    check("coll_code_again", 32'(code0), 32'h5);
    check("coll_ovf", 32'(ovf0), 32'h0);
    step(); check("coll_end", 32'(valid0), 32'h0);

    // Asynchronous reset mid-burst
    ready = 1'b0; req = 8'b0010_1010;
    step();
    req = 8'b0000_0010;
    step();
    req = '0;
    check("arst_pre_valid", 32'(valid0), 32'h1);
    check("arst_pre_ovf", 32'(ovf0), 32'h1);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_valid", 32'(valid0), 32'h0);
    check("arst_pend", 32'(pending0), 32'h00);
    check("arst_ovf", 32'(ovf0), 32'h0);
    check("arst_valid1", 32'(valid1), 32'h0);
    #2 rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("arst_quiet_valid", 32'(valid0), 32'h0);
      check("arst_quiet_pend", 32'(pending0), 32'h00);
    end

    // Lowest-first burst
    req = 8'b1010_0011;
    step();
    req = '0;
    step(); check("low_c0", 32'(code1), 32'h0);
    step(); check("low_c1", 32'(code1), 32'h1);
    step(); check("low_c5", 32'(code1), 32'h5);
    step(); check("low_c7", 32'(code1), 32'h7); check("low_v7", 32'(valid1), 32'h1);
    step(); check("low_end", 32'(valid1), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      req   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ready = ($urandom_range(0, 2) != 0);
      clr   = ($urandom_range(0, 7) == 0);
      step();
      compare_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/req_encoder.md
# req_encoder

Sequential 8-to-3 request encoder: the return direction for the 3-to-8 decoder. Each of eight request lines is latched into a pending register. The encoder then emits the index of every pending request as a 3-bit code, one code per valid/ready handshake, in fixed priority order. It sits between event sources (decoded strobes, interrupt lines) and a consumer that takes one binary code at a time.

## Interface
- `WIDTH`, default 3: code width; request count `N = 2**WIDTH`, which is 8 at the default.
- `LOW_FIRST`, default 0: selects the priority order.
  - 0: highest index served first.
  - 1: lowest index served first.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `req` input, N bits: request lines; `req[i]`=1 in a cycle raises request i.
- `clr` input, 1 bit: synchronous clear of the `ovf` flag.
- `code` output, WIDTH bits: index of the request being presented (registered).
- `valid` output, 1 bit: `code` is valid (registered).
- `ready` input, 1 bit: the consumer accepts `code`; a transfer happens when `valid && ready`.
- `pending` output, N bits: current pending register (registered).
- `ovf` output, 1 bit: sticky lost-request flag (registered).

## Operation
- **Reset values:** `pending`=0, `code`=0, `valid`=0, `ovf`=0, state=IDLE.
- **Pending update at each edge:**
  - `pending_next = (pending & ~ack_mask) | req`.
  - `ack_mask` is the one-hot of `code` when `valid && ready`, otherwise 0.
  - On a simultaneous set and clear of the same bit, the set wins; the new event is kept.
- **Priority pick:** chosen from `pending_next`; order set by `LOW_FIRST`.
- **State IDLE:** `valid`=0.
  - If `pending` is non-zero: load `code` with the pick from `pending`, set `valid`=1, go to HOLD.
- **State HOLD:** `valid`=1, and `code` is held stable until accepted.
  - An arrival of higher priority never preempts the held code.
- **Transfer in HOLD:**
  - If `pending_next` is non-zero: load the next pick from `pending_next`, keep `valid`=1, stay in HOLD. This gives back-to-back codes.
  - Otherwise: `valid`=0, go to IDLE.
- **Overflow:** `ovf` is set when `req[i]`=1 while `pending[i]`=1 and bit i is not being acked this edge.
  - `ovf` stays set until `clr`.
  - If `clr` and a new overflow occur in the same cycle, set wins.
- **Duplicate suppression:** a request held high for k cycles with no ack produces one code and sets `ovf`.
- **Reset mid-operation:** takes effect immediately (asynchronous). Pending requests and any in-flight code are discarded; `valid` drops without a handshake.

## Timing
- `req[i]` high in cycle t: `pending[i]`=1 from t+1; `code`/`valid` from t+2, provided the block is IDLE.
- Throughput: one code per cycle while `ready`=1 and requests remain pending.
- Transfer at edge e: the next code appears in the cycle after e. There is no bubble unless `pending_next` is 0.
- `valid` never deasserts without a transfer (except at reset).
- `code` never changes while `valid && !ready`.
- Wrap-around: none. Every index 0..N-1 is served; the pick restarts from the top priority on each selection.

## Structure
- Shared package `enc_pkg`:
  - state enum (IDLE, HOLD);
  - `WIDTH` default constant;
  - function `onehot(code)` returning an N-bit mask.
- Sub-module `prio_pick`: combinational, N-bit vector in, WIDTH-bit index out plus an `any` flag, `LOW_FIRST` parameter. It is instantiated twice: pick from `pending`, and pick from `pending_next`.
- FSM, pending register, and ovf logic live in `req_encoder`.

## Test plan
- **Single request, at reset then release:** `req`=8'b0000_0100 for one cycle, `ready`=1 → `code`=2 and `valid`=1 two cycles later, for one cycle; `pending` back to 0; `ovf`=0.
- **Multi-hot burst, `LOW_FIRST`=0:** `req`=8'b1010_0011 for one cycle, `ready`=1 → codes 7, 5, 1, 0 on consecutive cycles, then `valid`=0.
- **Backpressure:** `ready`=0 with codes 6 and 3 pending → `code`=6 held stable with `valid`=1 for 10 cycles. Asserting `req[7]` meanwhile does not change `code`. After `ready`=1 the sequence is 6, 7, 3.
- **Overflow:**
  - `req[4]` high for 3 cycles with `ready`=0 → one pending bit, `ovf`=1.
  - `clr` pulse → `ovf`=0.
  - `clr` coincident with a new overflow → `ovf` stays 1.
- **Set/ack collision:** `req[5]` asserted in the same cycle that code 5 is accepted → `pending[5]` stays 1 and code 5 is emitted again.
- **Async reset mid-burst:** assert `rst_n`=0 between edges while HOLD with 3 requests pending → `valid`, `pending`, and `ovf` go to 0 immediately. After release there is no output until new requests arrive. Repeat with `LOW_FIRST`=1 and burst 8'b1010_0011 → codes 0, 1, 5, 7.
